// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings and constants for the fetch stage
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10,
    ST_DROP = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with stall (hold) and flush (bubble)
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            load_valid_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;

  // A bubble keeps pcplus4 so the last real PC+4 stays visible downstream.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (!stall_i) begin
      if (flush_i || !load_valid_i) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d   = instr_i;
        pcplus4_d = pcplus4_i;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction-memory request FSM and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_decode,
  input  logic        flush_decode,
  input  logic [1:0]  pcsrc_decode,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_decode,
  output logic [31:0] pcplus4_decode,
  output logic        valid_decode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pcplus4_q, hold_pcplus4_d;

  logic [31:0]  pc_plus4, sel_pc, next_pc;
  logic         redirect, stalled;
  logic         if_load_valid;
  logic [31:0]  if_instr, if_pcplus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    sel_pc = pc_plus4;
    case (pcsrc_decode)
      PCSRC_BRANCH: sel_pc = branch_target;
      PCSRC_JUMP:   sel_pc = jump_target;
      PCSRC_JR:     sel_pc = jr_target;
      default:      sel_pc = pc_plus4;
    endcase
  end

  assign next_pc  = {sel_pc[31:2], 2'b00};
  assign redirect = (pcsrc_decode != PCSRC_SEQ) && !stall_pc;
  assign stalled  = stall_decode || stall_pc;

  // DROP keeps presenting the abandoned address until memory answers it.
  assign imem_req  = !rst && (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_addr_d    = drop_addr_q;
    hold_instr_d   = hold_instr_q;
    hold_pcplus4_d = hold_pcplus4_q;
    if_load_valid  = 1'b0;
    if_instr       = NOP_WORD;
    if_pcplus4     = pc_plus4;
    case (state_q)
      ST_REQ, ST_WAIT: begin
        if (imem_ack) begin
          if (redirect || !stalled) begin
            if_load_valid = 1'b1;
            if_instr      = imem_rdata;
            pc_d          = next_pc;
            state_d       = ST_REQ;
          end else begin
            hold_instr_d   = imem_rdata;
            hold_pcplus4_d = pc_plus4;
            state_d        = ST_HOLD;
          end
        end else if (redirect) begin
          drop_addr_d = pc_q;
          pc_d        = next_pc;
          state_d     = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end else if (!stalled) begin
          if_load_valid = 1'b1;
          if_instr      = hold_instr_q;
          if_pcplus4    = hold_pcplus4_q;
          pc_d          = next_pc;
          state_d       = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) pc_d = next_pc;
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_REQ;
      pc_q           <= {RESET_PC[31:2], 2'b00};
      drop_addr_q    <= '0;
      hold_instr_q   <= NOP_WORD;
      hold_pcplus4_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drop_addr_q    <= drop_addr_d;
      hold_instr_q   <= hold_instr_d;
      hold_pcplus4_q <= hold_pcplus4_d;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_decode),
    .flush_i     (flush_decode),
    .load_valid_i(if_load_valid),
    .instr_i     (if_instr),
    .pcplus4_i   (if_pcplus4),
    .instr_o     (instr_decode),
    .pcplus4_o   (pcplus4_decode),
    .valid_o     (valid_decode)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_pc, stall_decode, flush_decode;
  logic [1:0]  pcsrc_decode;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_decode, pcplus4_decode;
  logic        valid_decode;

  int checks = 0;
  int errors = 0;

  // Reference: program counter, one in-flight stale request, one parked word.
  logic [31:0] m_pc = RST_PC;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = '0;
  bit          m_hold = 1'b0;
  logic [31:0] m_hold_instr = '0, m_hold_p4 = '0;
  logic [31:0] m_instr = '0, m_p4 = '0;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .pcsrc_decode(pcsrc_decode),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_decode(instr_decode),
    .pcplus4_decode(pcplus4_decode), .valid_decode(valid_decode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16) return 32'hA0 + (a >> 2);
    return {a[31:16] ^ 16'h5A5A, a[15:0] ^ 16'h1234};
  endfunction

  task automatic bubble();
    if (!stall_decode) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] p4);
    if (!stall_decode) begin
      if (flush_decode) bubble();
      else begin
        m_instr = w;
        m_p4    = p4;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    bit          stalled, redir;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RST_PC; m_stale = 0; m_hold = 0;
      m_instr = 0; m_p4 = 0; m_valid = 0;
      return;
    end
    stalled = stall_decode || stall_pc;
    redir   = (pcsrc_decode != 2'b00) && !stall_pc;
    case (pcsrc_decode)
      2'b01:   tgt = branch_target;
      2'b10:   tgt = jump_target;
      default: tgt = jr_target;
    endcase
    tgt = tgt & 32'hFFFF_FFFC;
    if (m_stale) begin
      if (redir) m_pc = tgt;
      if (imem_ack) m_stale = 0;
      bubble();
    end else if (m_hold) begin
      if (redir) begin
        m_hold = 0; m_pc = tgt; bubble();
      end else if (!stalled) begin
        deliver(m_hold_instr, m_hold_p4); m_hold = 0; m_pc = m_pc + 4;
      end else bubble();
    end else if (imem_ack) begin
      if (redir || !stalled) begin
        deliver(imem_rdata, m_pc + 4);
        m_pc = redir ? tgt : m_pc + 4;
      end else begin
        m_hold = 1; m_hold_instr = imem_rdata; m_hold_p4 = m_pc + 4; bubble();
      end
    end else begin
      if (redir) begin
        m_stale = 1; m_stale_addr = m_pc; m_pc = tgt;
      end
      bubble();
    end
  endtask

  task automatic tick();
    logic        exp_req;
    logic [31:0] exp_addr;
    @(negedge clk);
    exp_req  = !rst && !m_hold;
    exp_addr = m_stale ? m_stale_addr : m_pc;
    if (!exp_req) imem_ack = 1'b0;
    imem_rdata = mem_word(exp_addr);
    #1;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    model_update();
    #1;
    check("instr_decode", instr_decode, m_instr);
    check("pcplus4_decode", pcplus4_decode, m_p4);
    check("valid_decode", valid_decode, m_valid);
  endtask

  task automatic idle();
    rst = 0; stall_pc = 0; stall_decode = 0; flush_decode = 0;
    pcsrc_decode = 2'b00; imem_ack = 0;
    branch_target = '0; jump_target = '0; jr_target = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    idle(); imem_rdata = '0;
    do_reset();
    check("reset_valid", valid_decode, 1'b0);
    check("reset_instr", instr_decode, 32'h0);

    // back-to-back zero-wait fetches
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1; tick();
      check("seq_instr", instr_decode, 32'hA0 + i);
      check("seq_addr", imem_addr, 32'(4 * (i + 1)));
    end

    // decode stall while the word for 8 arrives
    do_reset();
    imem_ack = 1; tick(); tick();
    stall_decode = 1; stall_pc = 1; tick(); tick();
    check("stall_keeps", instr_decode, 32'hA1);
    stall_decode = 0; stall_pc = 0; tick();
    check("release_word8", instr_decode, 32'hA2);
    imem_ack = 1; tick();
    check("after_word12", instr_decode, 32'hA3);

    // branch taken with flush
    imem_ack = 1; pcsrc_decode = 2'b01; branch_target = 32'h40; flush_decode = 1; tick();
    check("flush_bubble", valid_decode, 1'b0);
    check("branch_addr", imem_addr, 32'h40);

    // redirect while waiting on a slow response
    idle(); tick();
    pcsrc_decode = 2'b10; jump_target = 32'h80; tick();
    pcsrc_decode = 2'b00; tick();
    imem_ack = 1; tick();
    check("drop_valid", valid_decode, 1'b0);
    check("drop_addr", imem_addr, 32'h80);
    tick();
    check("jump_word", instr_decode, mem_word(32'h80));
    check("jump_valid", valid_decode, 1'b1);

    // reset abandons a waiting request
    imem_ack = 0; tick();
    rst = 1; tick(); rst = 0;
    check("rst_valid", valid_decode, 1'b0);
    check("rst_p4", pcplus4_decode, 32'h0);
    imem_ack = 1; tick();
    check("post_rst_word", instr_decode, mem_word(RST_PC));

    // address wrap-around
    pcsrc_decode = 2'b11; jr_target = 32'hFFFF_FFFF; tick();
    pcsrc_decode = 2'b00; tick();
    check("wrap_p4", pcplus4_decode, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_word", instr_decode, mem_word(32'hFFFF_FFFC));

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      stall_decode = ($urandom_range(0, 3) == 0);
      stall_pc     = stall_decode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      flush_decode = ($urandom_range(0, 4) == 0);
      pcsrc_decode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      imem_ack     = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
